// File: rtl/bus_pkg.sv
// Shared types and limits for the N-master bus arbiter.
package bus_pkg;

  localparam int unsigned ARB_MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_RESUME = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: first set bit of req_i at or after ptr_i, wrapping.
module rr_pick
  import bus_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [SUM_W-1:0] sum;

  // Rotate so ptr_i lands on bit 0, find the lowest set bit, then undo the rotation.
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (((rot >> i) & N'(1)) != '0) off = IDX_W'(i);
    end
    sum = SUM_W'(ptr_i) + SUM_W'(off);
    if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
    valid_o = |req_i;
    idx_o   = IDX_W'(sum);
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with tenure limit and split/resume support.
// Define ARB_ROUND_ROBIN_EN for round-robin fairness; otherwise lowest index wins.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  parameter  int unsigned MAX_HOLD    = 256,
  localparam int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_MASTERS-1:0] req_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  input  logic                   frame_active_i,
  input  logic                   split_i,
  input  logic                   split_release_i,
  output logic [IDX_W-1:0]       msel_o,
  output logic                   split_pending_o,
  output logic [NUM_MASTERS-1:0] split_owner_o,
  output logic                   busy_o
);

  localparam int unsigned             HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0]       HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [NUM_MASTERS-1:0]  ONE      = NUM_MASTERS'(1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   pend_q, pend_d;
  logic                   released_q, released_d;
  logic [NUM_MASTERS-1:0] split_oh_q, split_oh_d;
  logic [IDX_W-1:0]       split_idx_q, split_idx_d;

  logic [NUM_MASTERS-1:0] owner_oh, eligible;
  logic                   own_req, others, hold_expired, release_now, split_take, rearb;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx, pick_ptr;

  assign owner_oh     = ONE << owner_q;
  assign eligible     = req_i & ~split_oh_q;
  assign own_req      = |(req_i & owner_oh);
  assign others       = |(eligible & ~owner_oh);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q >= HOLD_MAX) && others;
  assign release_now  = pend_q & split_release_i;
  assign split_take   = (state_q == ARB_GRANT) && split_i && !pend_q && !split_release_i;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i   (eligible),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  assign pick_ptr = rr_ptr_q;

  // Pointer moves just past each newly granted master.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (rearb && !(pend_q && (released_q || release_now)) && pick_valid)
      rr_ptr_d = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_ptr = '0;
`endif

  // Next state; leaving GRANT/RESUME re-arbitrates in the same cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    split_oh_d  = split_oh_q;
    split_idx_d = split_idx_q;
    released_d  = released_q | release_now;
    rearb       = 1'b0;
    case (state_q)
      ARB_IDLE: rearb = 1'b1;
      ARB_GRANT: begin
        if (split_take) begin
          state_d     = ARB_IDLE;
          pend_d      = 1'b1;
          split_oh_d  = owner_oh;
          split_idx_d = owner_q;
        end else if (!frame_active_i && (!own_req || hold_expired)) begin
          rearb = 1'b1;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ARB_RESUME: rearb = !frame_active_i && !own_req;
      default:    rearb = 1'b1;
    endcase
    if (rearb) begin
      state_d = ARB_IDLE;
      if (pend_q && (released_q || release_now)) begin
        state_d    = ARB_RESUME;
        owner_d    = split_idx_q;
        pend_d     = 1'b0;
        split_oh_d = '0;
        released_d = 1'b0;
      end else if (pick_valid) begin
        state_d = ARB_GRANT;
        owner_d = pick_idx;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      hold_q      <= '0;
      pend_q      <= 1'b0;
      released_q  <= 1'b0;
      split_oh_q  <= '0;
      split_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      released_q  <= released_d;
      split_oh_q  <= split_oh_d;
      split_idx_q <= split_idx_d;
    end
  end

  // Zero-latency grant decoded from the next state.
  always_comb begin
    gnt_o  = '0;
    msel_o = '0;
    if (rst_ni && (state_d != ARB_IDLE)) begin
      gnt_o  = ONE << owner_d;
      msel_o = owner_d;
    end
  end

  assign split_pending_o = pend_q;
  assign split_owner_o   = split_oh_q;
  assign busy_o          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed steps plus random traffic against a tenure-level model.
module tb_bus_arbiter_rr;

  localparam int NM   = 4;
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst_n, frame, split, rel;
  logic [3:0] req, gnt_o, split_owner_o;
  logic [1:0] msel_o;
  logic       split_pending_o, busy_o;

  int checks   = 0;
  int failures = 0;

  // Model: owner -1 means bus idle; parked -1 means no split outstanding.
  int m_owner, m_parked, m_held, m_rr;
  bit m_resume, m_pending, m_released;
  int n_owner, n_parked, n_held, n_rr;
  bit n_resume, n_pending, n_released;
  logic [3:0] exp_gnt, exp_split;
  logic [1:0] exp_msel;
  logic       exp_pend, exp_busy;

  int         order[$];
  int         rr_exp[5] = '{0, 1, 2, 3, 0};
  logic [3:0] prev_gnt, exp_h;

  bus_arbiter_rr #(.NUM_MASTERS(NM), .MAX_HOLD(MAXH)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_i           (req),
    .gnt_o           (gnt_o),
    .frame_active_i  (frame),
    .split_i         (split),
    .split_release_i (rel),
    .msel_o          (msel_o),
    .split_pending_o (split_pending_o),
    .split_owner_o   (split_owner_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int i);
    return (i < 0) ? 4'b0000 : (4'b0001 << i);
  endfunction

  function automatic int pick(input logic [3:0] e, input int start);
    for (int k = 0; k < NM; k++)
      if ((e & oh((start + k) % NM)) != 4'b0000) return (start + k) % NM;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_parked = -1; m_held = 0; m_rr = 0;
    m_resume = 0; m_pending = 0; m_released = 0;
  endtask

  // One cycle of the arbitration rules, written over master indices.
  task automatic model_eval();
    logic [3:0] elig;
    bit         relv, leave, others;
    int         w, start;
    n_owner = m_owner; n_parked = m_parked; n_held = m_held; n_rr = m_rr;
    n_resume = m_resume; n_pending = m_pending; n_released = m_released;
    relv = m_released || (m_pending && rel);
    if (m_pending && rel) n_released = 1;
    elig = req & ~(m_pending ? oh(m_parked) : 4'b0000);
    leave = 0;
    if (m_owner < 0) leave = 1;
    else if (m_resume) leave = !frame && ((req & oh(m_owner)) == 4'b0000);
    else if (split && !m_pending && !rel) begin
      n_parked = m_owner; n_pending = 1; n_owner = -1;
    end else begin
      others = (elig & ~oh(m_owner)) != 4'b0000;
      if (!frame && (((req & oh(m_owner)) == 4'b0000) || (m_held >= MAXH && others))) leave = 1;
      else if (m_held < MAXH) n_held = m_held + 1;
    end
    if (leave) begin
      n_owner = -1; n_resume = 0;
      if (m_pending && relv) begin
        n_owner = m_parked; n_resume = 1; n_pending = 0; n_parked = -1; n_released = 0;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        start = m_rr;
`else
        start = 0;
`endif
        w = pick(elig, start);
        if (w >= 0) begin
          n_owner = w; n_held = 0; n_rr = (w + 1) % NM;
        end
      end
    end
    exp_gnt   = (rst_n && n_owner >= 0) ? oh(n_owner) : 4'b0000;
    exp_msel  = (rst_n && n_owner >= 0) ? 2'(n_owner) : 2'd0;
    exp_pend  = m_pending;
    exp_split = m_pending ? oh(m_parked) : 4'b0000;
    exp_busy  = (m_owner >= 0);
  endtask

  task automatic step();
    #1;
    model_eval();
    chk("gnt", 32'(gnt_o), 32'(exp_gnt));
    chk("msel", 32'(msel_o), 32'(exp_msel));
    chk("split_pending", 32'(split_pending_o), 32'(exp_pend));
    chk("split_owner", 32'(split_owner_o), 32'(exp_split));
    chk("busy", 32'(busy_o), 32'(exp_busy));
    chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_owner = n_owner; m_parked = n_parked; m_held = n_held; m_rr = n_rr;
      m_resume = n_resume; m_pending = n_pending; m_released = n_released;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'hF; frame = 1'b0; split = 1'b0; rel = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset holds everything quiet even with all masters requesting.
    step();
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_msel", 32'(msel_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    tick();
    rst_n = 1'b1;
    step();
    chk("rst_release_gnt", 32'(gnt_o), 32'h1);
    tick();

    // M0 drops: M1 wins, then M3 once M1 drops.
    req = 4'b1010;
    step();
    chk("arb_1010_gnt", 32'(gnt_o), 32'h2);
    chk("arb_1010_msel", 32'(msel_o), 32'h1);
    tick();
    req = 4'b1000;
    step();
    chk("arb_1000_gnt", 32'(gnt_o), 32'h8);
    tick();
    req = 4'b0100;
    step();
    chk("m2_gnt", 32'(gnt_o), 32'h4);
    tick();

    // Split M2; M0 takes the bus while M2 is parked.
    req = 4'b0101; split = 1'b1;
    step();
    tick();
    split = 1'b0;
    step();
    chk("split_owner", 32'(split_owner_o), 32'h4);
    chk("split_pend", 32'(split_pending_o), 32'h1);
    chk("split_m0_gnt", 32'(gnt_o), 32'h1);
    tick();
    split = 1'b1;
    step();
    chk("split_again_gnt", 32'(gnt_o), 32'h1);
    tick();
    split = 1'b0;
    step();
    chk("split_again_owner", 32'(split_owner_o), 32'h4);
    tick();
    req = 4'b0100;
    step();
    chk("parked_blocked_gnt", 32'(gnt_o), 32'h0);
    tick();
    rel = 1'b1;
    step();
    chk("resume_gnt", 32'(gnt_o), 32'h4);
    tick();
    rel = 1'b0;
    step();
    chk("resume_pend", 32'(split_pending_o), 32'h0);
    chk("resume_owner", 32'(split_owner_o), 32'h0);
    tick();
    req = 4'b0000; frame = 1'b1;
    step();
    chk("resume_noreq_gnt", 32'(gnt_o), 32'h4);
    tick();
    frame = 1'b0;
    step();
    chk("resume_exit_gnt", 32'(gnt_o), 32'h0);
    tick();
    rel = 1'b1;
    step();
    tick();
    rel = 1'b0; req = 4'b0001;
    step();
    chk("stray_rel_pend", 32'(split_pending_o), 32'h0);
    chk("stray_rel_gnt", 32'(gnt_o), 32'h1);
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    // Fairness: all request, tenures end on the hold limit.
    rst_n = 1'b0; req = 4'hF; frame = 1'b0;
    step();
    tick();
    rst_n = 1'b1; prev_gnt = 4'b0000;
    repeat (60) begin
      step();
      if (gnt_o != prev_gnt && gnt_o != 4'b0000) order.push_back(int'(msel_o));
      prev_gnt = gnt_o;
      tick();
    end
    chk("rr_tenures", 32'(order.size() >= 5), 32'(1));
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : -1, rr_exp[k]);

    // Hold limit: M0 gives way after MAX_HOLD registered cycles; frame defers M1's handover.
    rst_n = 1'b0; req = 4'b0011;
    step();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 22; c++) begin
      frame = (c >= 18 && c <= 20);
      step();
      exp_h = (c <= 8 || c == 21) ? 4'b0001 : 4'b0010;
      chk($sformatf("hold_c%0d", c), 32'(gnt_o), 32'(exp_h));
      tick();
    end
    frame = 1'b0;
`endif

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      frame = ($urandom_range(0, 3) == 0);
      split = ($urandom_range(0, 7) == 0);
      rel   = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
